fi_result_collector: RTL and testbench

//  Downstream stage of the fault-injection bench: consumes the per-cycle latched faulty (fl) and golden (gd)

---
 rtl/fi_pkg.sv | 16 +
 rtl/fi_popcount.sv | 17 +
 rtl/fi_result_collector.sv | 121 ++++++++++++
 tb/tb_fi_result_collector.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fi_pkg.sv
// Shared types and default widths for the fault-injection bench stages.
package fi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fi_state_e;

  // Defaults sized for the c17 campaign; the stimulus stage uses the same values.
  localparam int FI_OUT_W   = 2;
  localparam int FI_CNT_W   = 32;
  localparam int FI_NUM_INJ = 10000;

endpackage

// File: rtl/fi_popcount.sv
// Combinational population count of a W-bit vector.
module fi_popcount #(
  parameter int W = 2
) (
  input  logic [W-1:0]             vec,
  output logic [$clog2(W+1)-1:0]   cnt
);

  localparam int CW = $clog2(W + 1);

  // Sum of set bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + CW'(vec[i]);
  end

endmodule

// File: rtl/fi_result_collector.sv
// Compares faulty/golden samples, accumulates campaign statistics and emits
// one mismatch record per failing injection over a valid/ready channel.
module fi_result_collector
  import fi_pkg::*;
#(
  parameter int OUT_W   = FI_OUT_W,
  parameter int CNT_W   = FI_CNT_W,
  parameter int NUM_INJ = FI_NUM_INJ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             sample_valid,
  input  logic [OUT_W-1:0] fl_out,
  input  logic [OUT_W-1:0] gd_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] inj_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_idx,
  output logic [OUT_W-1:0] rec_mask
);

  localparam int               PC_W    = $clog2(OUT_W + 1);
  localparam int               SUM_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LAST_IX = CNT_W'(NUM_INJ - 1);

  fi_state_e state, state_nxt;

  logic             s1_vld;
  logic [CNT_W-1:0] s1_idx;
  logic [OUT_W-1:0] s1_diff;
  logic [PC_W-1:0]  s1_pc;
  logic [SUM_W-1:0] bit_sum;

  // go clears the campaign; abort always overrides it.
  wire go     = start && !abort && (state == S_IDLE || state == S_DONE);
  wire accept = sample_valid && !abort && (state == S_RUN);
  // Stage-1 mismatch that is allowed to touch stats/records (abort flushes it).
  wire s1_err = s1_vld && (|s1_diff) && !abort;

  fi_popcount #(.W(OUT_W)) u_pc (.vec(s1_diff), .cnt(s1_pc));

  assign bit_sum = {1'b0, bit_err_cnt} + SUM_W'(s1_pc);
  assign busy    = (state == S_RUN) || (state == S_DRAIN);
  assign done    = (state == S_DONE);

  // Next-state decode; DRAIN waits for the pipe and record slot to empty.
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_RUN;
        S_RUN:   if (accept && inj_cnt == LAST_IX) state_nxt = S_DRAIN;
        S_DRAIN: if (!s1_vld && !rec_valid) state_nxt = S_DONE;
        S_DONE:  if (start) state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Stage 1: capture index and XOR mask of each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0; s1_idx <= '0; s1_diff <= '0;
    end else if (abort || go) begin
      s1_vld <= 1'b0; s1_idx <= '0; s1_diff <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_idx  <= inj_cnt;
        s1_diff <= fl_out ^ gd_out;
      end
    end
  end

  // Campaign counters; error counters saturate, bit errors clamp on add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_cnt <= '0; err_cnt <= '0; bit_err_cnt <= '0; drop_cnt <= '0;
    end else if (go) begin
      inj_cnt <= '0; err_cnt <= '0; bit_err_cnt <= '0; drop_cnt <= '0;
    end else begin
      if (accept) inj_cnt <= inj_cnt + 1'b1;
      if (s1_err) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        bit_err_cnt <= bit_sum[CNT_W] ? CNT_MAX : bit_sum[CNT_W-1:0];
        if (rec_valid && !rec_ready && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Single-entry record slot; a held record is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_valid <= 1'b0; rec_idx <= '0; rec_mask <= '0;
    end else if (abort) begin
      rec_valid <= 1'b0;
    end else if (go) begin
      rec_valid <= 1'b0; rec_idx <= '0; rec_mask <= '0;
    end else if (s1_err && (!rec_valid || rec_ready)) begin
      rec_valid <= 1'b1; rec_idx <= s1_idx; rec_mask <= s1_diff;
    end else if (rec_valid && rec_ready) begin
      rec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fi_result_collector.sv
// Self-checking bench for fi_result_collector (NUM_INJ=8, OUT_W=2, CNT_W=8).
module tb_fi_result_collector;

  localparam int OUT_W = 2, CNT_W = 8, NUM_INJ = 8;

  logic             clk, rst_n, start, abort, sample_valid, rec_ready;
  logic [OUT_W-1:0] fl_out, gd_out, rec_mask;
  logic             busy, done, rec_valid;
  logic [CNT_W-1:0] inj_cnt, err_cnt, bit_err_cnt, drop_cnt, rec_idx;

  fi_result_collector #(.OUT_W(OUT_W), .CNT_W(CNT_W), .NUM_INJ(NUM_INJ)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sample_valid(sample_valid), .fl_out(fl_out), .gd_out(gd_out),
    .busy(busy), .done(done), .inj_cnt(inj_cnt), .err_cnt(err_cnt),
    .bit_err_cnt(bit_err_cnt), .drop_cnt(drop_cnt),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_idx(rec_idx), .rec_mask(rec_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] idx;
    logic [OUT_W-1:0] mask;
  } rec_t;

  typedef struct {
    logic [OUT_W-1:0] fl;
    logic [OUT_W-1:0] gd;
    logic             rec;
    logic [OUT_W-1:0] mask;
  } vec_t;

  rec_t             exp_q[$];
  rec_t             mon_e;
  vec_t             tbl[NUM_INJ];
  int               n_cmp = 0, n_bad = 0;
  logic [CNT_W-1:0] sidx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; sidx = '0;
  endtask

  // One accepted sample; optionally queue the record it must produce.
  task automatic send(input logic [OUT_W-1:0] fl, input logic [OUT_W-1:0] gd,
                      input logic push, input logic [OUT_W-1:0] mask);
    sample_valid = 1'b1; fl_out = fl; gd_out = gd;
    if (push) exp_q.push_back({sidx, mask});
    sidx++;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 50) begin tick(); n++; end
    check(name, {31'd0, done}, 32'd1);
  endtask

  // Scoreboard: every handshake must match the oldest expected record.
  always @(negedge clk) begin
    if (rst_n && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rec_unexpected: got idx %0d mask %b want none", rec_idx, rec_mask);
      end else begin
        mon_e = exp_q.pop_front();
        check("rec_idx", {24'd0, rec_idx}, {24'd0, mon_e.idx});
        check("rec_mask", {30'd0, rec_mask}, {30'd0, mon_e.mask});
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sample_valid = 1'b0;
    fl_out = '0; gd_out = '0; rec_ready = 1'b0; sidx = '0;

    tbl = '{'{2'b01, 2'b01, 1'b0, 2'b00}, '{2'b10, 2'b10, 1'b0, 2'b00},
            '{2'b11, 2'b00, 1'b1, 2'b11}, '{2'b00, 2'b00, 1'b0, 2'b00},
            '{2'b11, 2'b11, 1'b0, 2'b00}, '{2'b01, 2'b00, 1'b1, 2'b01},
            '{2'b10, 2'b10, 1'b0, 2'b00}, '{2'b00, 2'b00, 1'b0, 2'b00}};

    #12 rst_n = 1'b1;
    tick();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_inj", {24'd0, inj_cnt}, 0);
    check("rst_recv", {31'd0, rec_valid}, 0);

    // 1: async reset mid-RUN after three accepts.
    pulse_start();
    for (int i = 0; i < 3; i++) send(2'b11, 2'b00, 1'b0, 2'b00);
    check("t1_inj_pre", {24'd0, inj_cnt}, 3);
    tick();
    rst_n = 1'b0; #1;
    check("t1_busy", {31'd0, busy}, 0);
    check("t1_done", {31'd0, done}, 0);
    check("t1_inj", {24'd0, inj_cnt}, 0);
    check("t1_err", {24'd0, err_cnt}, 0);
    check("t1_bit", {24'd0, bit_err_cnt}, 0);
    check("t1_drop", {24'd0, drop_cnt}, 0);
    check("t1_recv", {31'd0, rec_valid}, 0);
    check("t1_recidx", {24'd0, rec_idx}, 0);
    #1 rst_n = 1'b1;
    tick();

    // 2: all samples match.
    rec_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < NUM_INJ; i++) send(2'(i), 2'(i), 1'b0, 2'b00);
    wait_done("t2_done");
    check("t2_inj", {24'd0, inj_cnt}, 8);
    check("t2_err", {24'd0, err_cnt}, 0);
    check("t2_bit", {24'd0, bit_err_cnt}, 0);
    check("t2_recv", {31'd0, rec_valid}, 0);

    // 3: table-driven campaign with two mismatches.
    pulse_start();
    for (int i = 0; i < NUM_INJ; i++) send(tbl[i].fl, tbl[i].gd, tbl[i].rec, tbl[i].mask);
    wait_done("t3_done");
    check("t3_err", {24'd0, err_cnt}, 2);
    check("t3_bit", {24'd0, bit_err_cnt}, 3);
    check("t3_drop", {24'd0, drop_cnt}, 0);
    check("t3_qleft", exp_q.size(), 0);

    // 4: back-pressure drops, DRAIN holds until the record is taken.
    rec_ready = 1'b0;
    pulse_start();
    send(2'b01, 2'b00, 1'b1, 2'b01);
    send(2'b10, 2'b00, 1'b0, 2'b00);
    send(2'b11, 2'b00, 1'b0, 2'b00);
    for (int i = 3; i < NUM_INJ; i++) send(2'b10, 2'b10, 1'b0, 2'b00);
    tick(); tick(); tick();
    check("t4_busy", {31'd0, busy}, 1);
    check("t4_done", {31'd0, done}, 0);
    check("t4_recv", {31'd0, rec_valid}, 1);
    check("t4_recidx", {24'd0, rec_idx}, 0);
    check("t4_recmask", {30'd0, rec_mask}, 1);
    check("t4_drop", {24'd0, drop_cnt}, 2);
    check("t4_err", {24'd0, err_cnt}, 3);
    check("t4_bit", {24'd0, bit_err_cnt}, 4);
    rec_ready = 1'b1;
    wait_done("t4_done_after");
    check("t4_qleft", exp_q.size(), 0);

    // 5: sample_valid ignored in DONE and after the last accept; restart clears.
    sample_valid = 1'b1; fl_out = 2'b01; gd_out = 2'b00;
    tick(); tick(); tick();
    check("t5_inj_done", {24'd0, inj_cnt}, 8);
    check("t5_err_done", {24'd0, err_cnt}, 3);
    sample_valid = 1'b0;
    pulse_start();
    check("t5_inj_clr", {24'd0, inj_cnt}, 0);
    check("t5_err_clr", {24'd0, err_cnt}, 0);
    check("t5_bit_clr", {24'd0, bit_err_cnt}, 0);
    check("t5_drop_clr", {24'd0, drop_cnt}, 0);
    check("t5_busy", {31'd0, busy}, 1);
    sample_valid = 1'b1; fl_out = 2'b10; gd_out = 2'b10;
    for (int i = 0; i < 12; i++) tick();
    check("t5_inj_held", {24'd0, inj_cnt}, 8);
    wait_done("t5_done");
    tick(); tick();
    check("t5_inj_final", {24'd0, inj_cnt}, 8);
    sample_valid = 1'b0;

    // 6: abort beats start; abort in RUN keeps counters and drops the record.
    start = 1'b1; abort = 1'b1; tick();
    check("t6_idle_a", {31'd0, done}, 0);
    tick();
    start = 1'b0; abort = 1'b0;
    check("t6_busy_a", {31'd0, busy}, 0);
    check("t6_done_a", {31'd0, done}, 0);
    check("t6_inj_a", {24'd0, inj_cnt}, 8);
    rec_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) send(2'b01, 2'b01, 1'b0, 2'b00);
    send(2'b10, 2'b01, 1'b0, 2'b00);
    tick();
    check("t6_recv_pre", {31'd0, rec_valid}, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t6_busy_b", {31'd0, busy}, 0);
    check("t6_recv_b", {31'd0, rec_valid}, 0);
    check("t6_inj_b", {24'd0, inj_cnt}, 4);
    check("t6_err_b", {24'd0, err_cnt}, 1);
    tick(); tick();
    check("t6_inj_hold", {24'd0, inj_cnt}, 4);
    check("t6_busy_hold", {31'd0, busy}, 0);

    check("q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
